// File: rtl/macu_pkg.sv
// Shared definitions for the macu8x8 multiply-accumulate stage:
// operand/product widths and the output register state encoding.
package macu_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Output register occupancy; kept as plain constants so older tools
    // that dislike enums in ports can still consume the encoding.
    typedef logic [0:0] out_state_t;
    localparam out_state_t OUT_EMPTY = 1'b0;
    localparam out_state_t OUT_FULL  = 1'b1;

endpackage

// File: rtl/macu8x8_if.sv
// Operand stream and result stream of the macu8x8 stage.
// master = producer of operands / consumer of results, slave = the MAC.
interface macu8x8_if
    import macu_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int COUNT_W = 8
);

    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    in_a;
    logic [OP_W-1:0]    in_b;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [COUNT_W-1:0] out_count;
    logic               out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/mplieru8x8.sv
// Combinational 8x8 unsigned multiplier, full 16-bit product.
module mplieru8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    assign p = a * b;

endmodule

// File: rtl/macu8x8.sv
// Streaming unsigned dot-product stage: registers each 8x8 product (P stage),
// accumulates a vector until its last pair, then parks the result in a
// valid/ready output register.
// Optional build macro: MACU_SATURATE_EN -- when defined the running sum
// clamps to all ones on the first carry instead of wrapping.
//
// Output register states:
//   state     | meaning
//   OUT_EMPTY | no result held, out_valid=0
//   OUT_FULL  | result held until the consumer takes it, out_valid=1
module macu8x8
    import macu_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int COUNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    macu8x8_if.slave   bus
);

    logic [PROD_W-1:0]  mul_p;

    logic               p_valid_q, p_valid_d;
    logic               p_last_q,  p_last_d;
    logic [PROD_W-1:0]  p_prod_q,  p_prod_d;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    out_state_t         out_state_q, out_state_d;
    logic [ACC_W-1:0]   out_sum_q,   out_sum_d;
    logic [COUNT_W-1:0] out_count_q, out_count_d;
    logic               out_ovf_q,   out_ovf_d;

    logic               out_valid;
    logic               stall;
    logic               in_hs;
    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   acc_next;
    logic [COUNT_W-1:0] cnt_next;
    logic               ovf_next;

    mplieru8x8 u_mul (
        .a (bus.in_a),
        .b (bus.in_b),
        .p (mul_p)
    );

    assign out_valid = (out_state_q == OUT_FULL);

    // A last product can only retire into an output register that is free or being drained.
    always_comb begin
        stall = p_valid_q && p_last_q && out_valid && !bus.out_ready;
        in_hs = bus.in_valid && !stall;
    end

    // P stage: capture the accepted pair's product, or bubble, unless stalled.
    always_comb begin
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        p_prod_d  = p_prod_q;
        if (!stall) begin
            p_valid_d = in_hs;
            if (in_hs) begin
                p_last_d = bus.in_last;
                p_prod_d = mul_p;
            end
        end
    end

    // Next running sum; carry detection is shared by wrap and saturate modes.
    always_comb begin
        sum_ext  = {1'b0, acc_q} + (ACC_W+1)'(p_prod_q);
        carry    = sum_ext[ACC_W];
`ifdef MACU_SATURATE_EN
        // Once saturated the sum is pinned for the rest of the vector.
        acc_next = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_next = sum_ext[ACC_W-1:0];
`endif
        cnt_next = cnt_q + COUNT_W'(1);
        ovf_next = ovf_q | carry;
    end

    // Retire the P product into the accumulator or, on last, into the output register.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_state_d = out_state_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (p_valid_q && !p_last_q) begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            ovf_d = ovf_next;
        end

        if (p_valid_q && p_last_q && !stall) begin
            // Capture wins over a same-cycle drain, so FULL stays FULL.
            out_state_d = OUT_FULL;
            out_sum_d   = acc_next;
            out_count_d = cnt_next;
            out_ovf_d   = ovf_next;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
        end else if (out_valid && bus.out_ready) begin
            out_state_d = OUT_EMPTY;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_prod_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_state_q <= OUT_EMPTY;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            p_prod_q    <= p_prod_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_state_q <= out_state_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule
